// File: rtl/ss_addsub_accum.sv
// Signed N-input stochastic adder/subtractor with a saturating residual accumulator.
// Optional overflow event counter is built only when SS_ADDSUB_OVFCNT_EN is defined.
module ss_addsub_accum #(
  parameter int N        = 6,
  parameter int ACC_W    = 6,
  parameter int OVFCNT_W = 8
) (
  input  logic                CLK,
  input  logic                INIT_N,
  input  logic                CLR,
  input  logic                EN,
  input  logic [N-1:0]        IN,
  input  logic [N-1:0]        SIGN,
  output logic                OUT,
  output logic                SIGN_out,
  output logic                OVF,
  output logic [ACC_W-1:0]    ACC_out,
  output logic [OVFCNT_W-1:0] OVF_CNT
);

  localparam int PW        = $clog2(N + 1);
  localparam int TW        = ACC_W + 1;
  localparam int SAT_MAX_I = (1 << (ACC_W - 1)) - 1;

  localparam logic signed [TW-1:0] SAT_MAX = TW'(SAT_MAX_I);
  localparam logic signed [TW-1:0] SAT_MIN = TW'(-SAT_MAX_I);

  logic [PW-1:0]          pos_cnt;
  logic [PW-1:0]          neg_cnt;
  logic signed [TW-1:0]   t_val;
  logic signed [TW-1:0]   adj_val;
  logic signed [TW-1:0]   sat_val;
  logic                   t_neg;
  logic                   t_zero;
  logic                   clip;

  logic [ACC_W-1:0]       acc_q, acc_d;
  logic                   out_q, out_d;
  logic                   sign_q, sign_d;
  logic                   ovf_q, ovf_d;

  always_comb begin
    pos_cnt = '0;
    neg_cnt = '0;
    for (int i = 0; i < N; i++) begin
      pos_cnt = pos_cnt + PW'(IN[i] & ~SIGN[i]);
      neg_cnt = neg_cnt + PW'(IN[i] & SIGN[i]);
    end
  end

  // One extra bit of headroom keeps ACC + D from wrapping before the clip.
  always_comb begin
    t_val  = {acc_q[ACC_W-1], acc_q} + TW'(pos_cnt) - TW'(neg_cnt);
    t_neg  = t_val[TW-1];
    t_zero = (t_val == '0);
    adj_val = t_neg ? (t_val + TW'(1)) : (t_val - TW'(1));
  end

  always_comb begin
    sat_val = adj_val;
    clip    = 1'b0;
    if (adj_val > SAT_MAX) begin
      sat_val = SAT_MAX;
      clip    = 1'b1;
    end else if (adj_val < SAT_MIN) begin
      sat_val = SAT_MIN;
      clip    = 1'b1;
    end
  end

  always_comb begin
    acc_d  = acc_q;
    out_d  = 1'b0;
    sign_d = sign_q;
    ovf_d  = 1'b0;
    if (CLR) begin
      acc_d  = '0;
      sign_d = 1'b0;
    end else if (EN) begin
      if (t_zero) begin
        acc_d = '0;
      end else begin
        out_d  = 1'b1;
        sign_d = t_neg;
        acc_d  = sat_val[ACC_W-1:0];
        ovf_d  = clip;
      end
    end
  end

  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      acc_q  <= '0;
      out_q  <= 1'b0;
      sign_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      out_q  <= out_d;
      sign_q <= sign_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef SS_ADDSUB_OVFCNT_EN
  logic [OVFCNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (CLR) begin
      cnt_d = '0;
    end else if (ovf_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + OVFCNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign OVF_CNT = cnt_q;
`else
  assign OVF_CNT = '0;
`endif

  assign OUT      = out_q;
  assign SIGN_out = sign_q;
  assign OVF      = ovf_q;
  assign ACC_out  = acc_q;

endmodule

// File: doc/ss_addsub_accum.md
# ss_addsub_accum

Parametrised N-input signed stochastic adder/subtractor with a multi-bit residual accumulator, replacing the 1-bit carry scheme. Each cycle it counts positive and negative input pulses. It emits at most one signed output pulse and carries all uncommitted pulses forward in a saturating signed accumulator, so the output stream averages to the clipped sum of the inputs. It sits between neuron product terms and the activation stage of the stochastic datapath.

## Interface

Parameters:
- N, 6, number of input bitstreams.
- ACC_W, 6, residual accumulator width, two's complement. Must satisfy ACC_W >= PW+1, where PW = $clog2(N+1).
- OVFCNT_W, 8, width of the overflow event counter.

Ports:
- CLK, in, 1, clock; all state updates on the rising edge.
- INIT_N, in, 1, asynchronous active-low reset.
- CLR, in, 1, synchronous clear.
- EN, in, 1, advance enable.
- IN, in, N, input stochastic bits.
- SIGN, in, N, per-input sign; 1 = negative.
- OUT, out, 1, registered output pulse.
- SIGN_out, out, 1, registered sign of OUT; 1 = negative.
- OVF, out, 1, registered one-cycle flag: the residual was clipped this cycle.
- ACC_out, out, ACC_W, current residual, signed; exposed for observation.
- OVF_CNT, out, OVFCNT_W, saturating count of OVF events.

## Operation

- P = popcount(IN & ~SIGN). M = popcount(IN & SIGN). D = P - M, signed, range -N..N.
- T = ACC + D, computed sign-extended in ACC_W+1 bits so there is no intermediate wrap.
- Case T > 0: OUT<=1, SIGN_out<=0, ACC<=sat(T-1).
- Case T < 0: OUT<=1, SIGN_out<=1, ACC<=sat(T+1).
- Case T == 0: OUT<=0, SIGN_out holds, ACC<=0.
- sat() clips symmetrically to ±(2^(ACC_W-1)-1); the value -2^(ACC_W-1) is never stored.
  - OVF<=1 exactly when sat() changed its argument; otherwise OVF<=0.
- Pulses of opposite sign cancel within a cycle and against the stored residual. A residual never emits a pulse of the opposite sign to its own.
- EN=0: ACC holds, SIGN_out holds, OUT<=0, OVF<=0, and IN/SIGN are ignored.
- CLR=1: ACC<=0, OUT<=0, SIGN_out<=0, OVF<=0, OVF_CNT<=0.
  - CLR takes priority over EN and over any saturation on the same edge.
- INIT_N low, at any time including mid-stream: all outputs and state go to 0 immediately and stay there while INIT_N is low. The first update occurs on the first rising CLK edge after deassertion.

## Timing

- Latency: one cycle. IN/SIGN sampled at edge k determine OUT, SIGN_out, OVF and ACC_out after edge k.
- A burst of K net pulses in one cycle with ACC=0 produces K consecutive OUT=1 cycles, provided no saturation occurs and subsequent inputs are zero.
- Reset values:
  - OUT=0
  - SIGN_out=0
  - OVF=0
  - ACC_out=0
  - OVF_CNT=0
- All outputs are registered; there is no combinational path from IN/SIGN to any output.

## Configuration

- Macro SS_ADDSUB_OVFCNT_EN.
- Defined:
  - OVF_CNT increments on every edge where OVF is set.
  - It saturates at 2^OVFCNT_W-1.
  - It is cleared by CLR or INIT_N.
- Not defined:
  - No counter logic is built.
  - OVF_CNT is tied to 0.
  - OVF is unaffected.

## Test plan

All scenarios use N=6 and ACC_W=6 (residual range ±31).

- Reset: INIT_N=0 mid-stream with ACC=12 -> immediately OUT=0, SIGN_out=0, ACC_out=0, OVF_CNT=0. First update on the first edge after release.
- Burst drain: one cycle IN=000011, SIGN=0, then IN=0 -> OUT=1,1,0 on three consecutive cycles; ACC_out=1,0,0; SIGN_out=0.
- Cancellation: IN=111111, SIGN=000111, ACC=0 -> OUT=0, ACC_out=0, SIGN_out unchanged. Repeat with ACC=4 -> OUT=1, SIGN_out=0, ACC_out=3.
- Saturation: IN=111111, SIGN=0 held for 8 cycles from ACC=0 -> ACC_out=5,10,15,20,25,30,31,31 and OUT=1 throughout. OVF=1 on cycles 7 and 8 only. With the macro defined, OVF_CNT=2.
- Sign crossing: ACC=3, then IN=111111, SIGN=111111 for one cycle -> T=-3, OUT=1, SIGN_out=1, ACC_out=-2. Then IN=0 -> two further negative pulses, ACC_out=-1,0.
- Control priority:
  - EN=0 with IN=111111 -> OUT=0 and ACC holds.
  - CLR=1 together with EN=1 and a saturating input -> ACC_out=0, OVF=0, OVF_CNT=0.
